// File: rtl/dda_sequencer.sv
// Command decoder and step scheduler for the posit Van der Pol DDA integrator.
// Holds mu/icx/icy, paces integration steps with a prescaler and latches coherent snapshots.
module dda_sequencer #(
  parameter int N  = 16,
  parameter int DW = 16,
  parameter int SW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          frame_valid,
  input  logic [31:0]   frame_data,
  input  logic [N-1:0]  x,
  input  logic [N-1:0]  y,
  input  logic          snap_req,
  output logic          dda_en,
  output logic          dda_load,
  output logic [N-1:0]  mu,
  output logic [N-1:0]  icx,
  output logic [N-1:0]  icy,
  output logic [N-1:0]  snap_x,
  output logic [N-1:0]  snap_y,
  output logic [SW-1:0] snap_step,
  output logic [SW-1:0] step_count,
  output logic          running,
  output logic          cmd_err
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_BURST} state_t;

  localparam logic [3:0] OP_WR_MU  = 4'h1;
  localparam logic [3:0] OP_WR_ICX = 4'h2;
  localparam logic [3:0] OP_WR_ICY = 4'h3;
  localparam logic [3:0] OP_WR_DIV = 4'h4;
  localparam logic [3:0] OP_LOAD   = 4'h5;
  localparam logic [3:0] OP_RUN    = 4'h6;
  localparam logic [3:0] OP_STOP   = 4'h7;
  localparam logic [3:0] OP_STEP   = 4'h8;

  state_t        state, next_state;
  logic [DW-1:0] div, div_cnt;
  logic [15:0]   remaining;
  logic          restart;
  logic          burst_start;
  logic          active;

  logic [3:0]  opcode;
  logic [15:0] payload;
  assign opcode  = frame_data[31:28];
  assign payload = frame_data[15:0];

  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= next_state;
  end

  // Frame commands override the automatic LOAD->IDLE and burst-complete transitions.
  always_comb begin
    next_state  = state;
    restart     = 1'b0;
    burst_start = 1'b0;
    case (state)
      S_LOAD:  next_state = S_IDLE;
      S_BURST: if (dda_en && remaining == 16'd1) next_state = S_IDLE;
      default: ;
    endcase
    if (frame_valid) begin
      case (opcode)
        OP_LOAD: next_state = S_LOAD;
        OP_RUN: begin
          if (state == S_IDLE || state == S_BURST) begin
            next_state = S_RUN;
            restart    = 1'b1;
          end
        end
        OP_STOP: if (state != S_LOAD) next_state = S_IDLE;
        OP_STEP: begin
          if (payload != 16'd0 && state != S_LOAD) begin
            next_state  = S_BURST;
            burst_start = 1'b1;
            restart     = (state == S_IDLE);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    active   = (state == S_RUN) || (state == S_BURST);
    running  = active;
    dda_load = (state == S_LOAD);
    dda_en   = active && (div_cnt >= div);
  end

  // Parameter registers and the command error pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mu      <= N'(16'h3000);
      icx     <= N'(16'h3000);
      icy     <= N'(16'h3000);
      div     <= DW'(16'd999);
      cmd_err <= 1'b0;
    end else begin
      cmd_err <= frame_valid && (opcode >= 4'h9);
      if (frame_valid) begin
        case (opcode)
          OP_WR_MU:  mu  <= payload[N-1:0];
          OP_WR_ICX: icx <= payload[N-1:0];
          OP_WR_ICY: icy <= payload[N-1:0];
          OP_WR_DIV: div <= payload[DW-1:0];
          default: ;
        endcase
      end
    end
  end

  // Prescaler, burst counter and step counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      remaining  <= '0;
      step_count <= '0;
    end else begin
      if (!(next_state == S_RUN || next_state == S_BURST) || restart || dda_en)
        div_cnt <= '0;
      else
        div_cnt <= div_cnt + 1'b1;

      if (burst_start)
        remaining <= payload;
      else if (next_state != S_BURST)
        remaining <= '0;
      else if (dda_en)
        remaining <= remaining - 16'd1;

      if (frame_valid && opcode == OP_LOAD)
        step_count <= '0;
      else if (dda_en)
        step_count <= step_count + 1'b1;
    end
  end

  // Sampling pre-edge values keeps the snapshot coherent with a coincident step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      snap_x    <= '0;
      snap_y    <= '0;
      snap_step <= '0;
    end else if (snap_req) begin
      snap_x    <= x;
      snap_y    <= y;
      snap_step <= step_count;
    end
  end

endmodule

// File: doc/dda_sequencer.md
# dda_sequencer

Control and scheduling block for the posit Van der Pol DDA integrator. It decodes 32-bit command frames from the SPI receiver and holds the system parameters (mu, icx, icy). It sequences integration with a programmable-rate step enable, supporting free-run, stop and N-step bursts, and latches a coherent snapshot of the integrator state for SPI readout. It sits between the SPI front end and the `dda` instance, replacing ad-hoc stepping on chip-select edges.

## Interface
- N, 16, posit word width of x, y, mu, icx, icy
- DW, 16, prescaler divider width
- SW, 32, step counter width
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- frame_valid  in  1  one-cycle pulse: frame_data holds a complete received frame
- frame_data  in  32  command frame, opcode [31:28], payload [15:0]
- x, y  in  N  integrator state; updates on the clk edge at which dda_en=1
- snap_req  in  1  one-cycle pulse from SPI at message start
- dda_en  out  1  integrator step enable, one cycle per step
- dda_load  out  1  one-cycle pulse: integrator loads icx/icy
- mu, icx, icy  out  N  parameter registers
- snap_x, snap_y  out  N  latched state for readout
- snap_step  out  SW  step_count latched together with snap_x and snap_y
- step_count  out  SW  steps taken since last LOAD
- running  out  1  high in RUN or BURST
- cmd_err  out  1  one-cycle pulse on unknown opcode

## Operation
- Opcodes:
  - 0x0 NOP
  - 0x1 WR_MU: mu <= payload
  - 0x2 WR_ICX: icx <= payload
  - 0x3 WR_ICY: icy <= payload
  - 0x4 WR_DIV: div <= payload
  - 0x5 LOAD
  - 0x6 RUN
  - 0x7 STOP
  - 0x8 STEP: n = payload
  - 0x9–0xF: cmd_err pulse, no other effect
- FSM states: IDLE, LOAD, RUN, BURST. Reset state is IDLE.
- LOAD (accepted from any state): step_count <= 0, state -> LOAD for exactly one cycle with dda_load=1, then IDLE. dda_en is never asserted in LOAD.
- RUN:
  - From IDLE or BURST: -> RUN, and div_cnt <= 0.
  - In RUN: ignored; the prescaler keeps counting.
- STOP: -> IDLE from any state except LOAD, where it is a no-op.
- STEP n:
  - n=0: no-op.
  - Otherwise -> BURST with remaining <= n. div_cnt <= 0 unless already in RUN/BURST.
  - Each dda_en decrements remaining. The dda_en that brings remaining to 0 returns the FSM to IDLE on the same edge. Exactly n pulses are produced.
- Prescaler:
  - dda_en = (state ∈ {RUN, BURST}) && (div_cnt >= div), decoded from registers only, with no path from frame inputs.
  - div_cnt <= 0 when dda_en=1, else div_cnt+1. It holds at 0 outside RUN/BURST.
  - The >= compare means a WR_DIV lowering div below the current div_cnt fires on the next cycle rather than wrapping.
- step_count increments (mod 2^SW) on every dda_en.
- Parameter writes are accepted in every state. icx/icy changes reach the integrator only at the next LOAD; mu changes reach it immediately.
- Snapshot: on snap_req, snap_x <= x, snap_y <= y, snap_step <= step_count, all sampled in the same cycle. If dda_en=1 in that cycle, all three hold pre-step values, so the snapshot is always coherent.
- Reset values:
  - mu = icx = icy = 16'h3000, div = 16'd999
  - div_cnt, remaining, step_count, snap_* = 0
  - dda_en = dda_load = cmd_err = running = 0
- Reset asserted mid-RUN/BURST: no dda_en pulses in the cycle after reset is sampled; the burst is abandoned.

## Timing
- A frame with frame_valid in cycle T takes effect at the edge ending T. Registers, state and cmd_err are visible in T+1.
- A dda_en decoded in cycle T is still issued even if a STOP arrives in T.
- LOAD at T: dda_load=1 in T+1, step_count=0 in T+1.
- RUN at T from IDLE: first dda_en in T+1+div, then one every div+1 cycles. div=0 gives dda_en every cycle.
- STEP n at T from IDLE: pulses in T+1+div+k(div+1) for k = 0..n-1; running=0 from the cycle after the last pulse.
- A snap_req in T makes snap_* valid in T+1.
- frame_valid and snap_req in the same cycle are independent and both are honoured.

## Test plan
- Reset, then no frames for 2000 cycles -> dda_en never 1; mu=icx=icy=0x3000; running=0.
- WR_DIV 3, RUN at T -> dda_en at T+4, T+8, T+12; after 10 pulses step_count=10; STOP -> no further pulses; running=0 at the cycle after STOP is accepted.
- WR_DIV 0, STEP 5 -> exactly 5 consecutive dda_en cycles, then IDLE; STEP 0 -> no pulses, no state change.
- WR_ICX 0x4000, LOAD -> single dda_load pulse one cycle after accept; step_count=0; a RUN sent in the same frame stream afterwards starts counting from 0.
- snap_req coincident with dda_en while x=0x1234 pre-step -> snap_x=0x1234 and snap_step equals the pre-increment count.
- Opcode 0xA -> cmd_err pulse for one cycle, all registers and state unchanged. WR_DIV 2 issued while div_cnt=7 under div=999 -> dda_en on the next cycle.
